// File: rtl/vga_arb_pkg.sv
// Shared constants and helpers for the VGA framebuffer write arbiter.
package vga_arb_pkg;

    localparam int unsigned MODE_SLICE = 0;
    localparam int unsigned MODE_RR    = 1;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick
    import vga_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int unsigned   pos;
    logic [IW-1:0] pos_idx;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (!found && req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Merges N framebuffer write masters onto one VGA RAM write port, either by
// time-sliced ownership or per-beat round-robin, with a single registered output beat.
module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter  int unsigned N_CH      = 4,
    parameter  int unsigned ADDR_W    = 19,
    parameter  int unsigned DATA_W    = 16,
    parameter  int unsigned SLICE_LEN = 1024,
    parameter  int unsigned MODE      = MODE_SLICE,
    localparam int unsigned GW        = clog2_min1(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*ADDR_W-1:0]   req_addr,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          req_ready,
    input  logic                     mem_ready,
    output logic                     wr,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        dwrite,
    output logic [GW-1:0]            grant_id
);

    localparam int unsigned CW = clog2_min1(SLICE_LEN);

    logic [CW-1:0]     slice_cnt;
    logic [GW-1:0]     rr_ptr;
    logic              rr_found;
    logic [GW-1:0]     rr_idx;
    logic [GW-1:0]     sel;
    logic              sel_valid;
    logic              can_accept;
    logic              accept;
    logic [ADDR_W-1:0] ch_addr [N_CH];
    logic [DATA_W-1:0] ch_data [N_CH];

    // Unflatten the per-master buses.
    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign ch_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign ch_data[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(.N(N_CH)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    function automatic logic [GW-1:0] next_ch(input logic [GW-1:0] g);
        return (g == GW'(N_CH - 1)) ? '0 : g + GW'(1);
    endfunction

    // Channel selection and handshake; nothing is accepted while in reset.
    always_comb begin
        can_accept = !wr || mem_ready;
        if (MODE == MODE_RR) begin
            sel       = rr_idx;
            sel_valid = rr_found;
        end else begin
            sel       = grant_id;
            sel_valid = req_valid[grant_id];
        end
        accept    = can_accept && sel_valid && !rst;
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr        <= 1'b0;
            addr      <= '0;
            dwrite    <= '0;
            grant_id  <= '0;
            slice_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            // Output beat holds while the RAM stalls; drains when accepted.
            if (accept) begin
                wr     <= 1'b1;
                addr   <= ch_addr[sel];
                dwrite <= ch_data[sel];
            end else if (mem_ready) begin
                wr     <= 1'b0;
            end

            if (MODE == MODE_RR) begin
                slice_cnt <= '0;
                if (accept) begin
                    grant_id <= sel;
                    rr_ptr   <= next_ch(sel);
                end
            end else begin
                // Slice counter free-runs regardless of stalls.
                rr_ptr <= '0;
                if (slice_cnt == CW'(SLICE_LEN - 1)) begin
                    slice_cnt <= '0;
                    grant_id  <= next_ch(grant_id);
                end else begin
                    slice_cnt <= slice_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: a slice-mode and a round-robin instance share stimulus
// and are checked against a cycle-by-cycle reference model plus a write scoreboard.
module tb_vga_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int SL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              mem_ready;
    logic [AW-1:0]     ch_addr [N];
    logic [DW-1:0]     ch_data [N];

    logic [1:0]             d_wr;
    logic [1:0][AW-1:0]     d_addr;
    logic [1:0][DW-1:0]     d_dw;
    logic [1:0][1:0]        d_gid;
    logic [1:0][N-1:0]      d_rdy;

    for (genvar gi = 0; gi < N; gi++) begin : g_bus
        assign req_addr[gi*AW +: AW] = ch_addr[gi];
        assign req_data[gi*DW +: DW] = ch_data[gi];
    end

    vga_write_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .SLICE_LEN(SL), .MODE(0)) u_slice (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(d_rdy[0]), .mem_ready(mem_ready), .wr(d_wr[0]), .addr(d_addr[0]),
        .dwrite(d_dw[0]), .grant_id(d_gid[0])
    );

    vga_write_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .SLICE_LEN(SL), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(d_rdy[1]), .mem_ready(mem_ready), .wr(d_wr[1]), .addr(d_addr[1]),
        .dwrite(d_dw[1]), .grant_id(d_gid[1])
    );

    // Reference model state: index 0 = slice instance, 1 = round-robin instance.
    bit              m_wr   [2];
    logic [AW-1:0]   m_addr [2];
    logic [DW-1:0]   m_data [2];
    int              m_gid  [2];
    int              cyc;
    int              rr_start;
    int              wcnt   [2];
    logic [AW+DW-1:0] sbq0[$];
    logic [AW+DW-1:0] sbq1[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel the specification's rules select this cycle, or -1.
    function automatic int pick(input int m);
        int c;
        if (m == 0) begin
            c = (cyc / SL) % N;
            return req_valid[c] ? c : -1;
        end
        for (int k = 0; k < N; k++) begin
            c = (rr_start + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic sb_pop(input int m, input logic [AW+DW-1:0] w);
        int sz;
        logic [AW+DW-1:0] e;
        sz = (m == 0) ? sbq0.size() : sbq1.size();
        checks++;
        assert (sz != 0) else begin
            failures++;
            $error("FAIL sb_unexpected_write_m%0d observed=%0h expected=none", m, w);
        end
        if (sz != 0) begin
            e = (m == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk($sformatf("sb_beat_m%0d", m), 32'(w), 32'(e));
        end
    endtask

    task automatic cycle();
        int   sel [2];
        bit   acc [2];
        logic [N-1:0] exp_rdy;
        #1;
        for (int m = 0; m < 2; m++) begin
            sel[m]  = pick(m);
            acc[m]  = !rst && (!m_wr[m] || mem_ready) && (sel[m] >= 0);
            exp_rdy = acc[m] ? N'(1 << sel[m]) : '0;
            chk($sformatf("req_ready_m%0d", m), 32'(d_rdy[m]), 32'(exp_rdy));
            if (!rst && d_wr[m] === 1'b1 && mem_ready) begin
                wcnt[m]++;
                sb_pop(m, {d_addr[m], d_dw[m]});
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_wr[m] = 1'b0; m_addr[m] = '0; m_data[m] = '0; m_gid[m] = 0;
            end
            cyc = 0; rr_start = 0;
            sbq0.delete(); sbq1.delete();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (acc[m]) begin
                    m_wr[m]   = 1'b1;
                    m_addr[m] = ch_addr[sel[m]];
                    m_data[m] = ch_data[sel[m]];
                    if (m == 0) sbq0.push_back({m_addr[m], m_data[m]});
                    else        sbq1.push_back({m_addr[m], m_data[m]});
                    if (m == 1) begin
                        m_gid[1] = sel[1];
                        rr_start = (sel[1] + 1) % N;
                    end
                end else if (mem_ready) begin
                    m_wr[m] = 1'b0;
                end
            end
            cyc++;
            m_gid[0] = (cyc / SL) % N;
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("wr_m%0d", m),       32'(d_wr[m]),   32'(m_wr[m]));
            chk($sformatf("addr_m%0d", m),     32'(d_addr[m]), 32'(m_addr[m]));
            chk($sformatf("dwrite_m%0d", m),   32'(d_dw[m]),   32'(m_data[m]));
            chk($sformatf("grant_id_m%0d", m), 32'(d_gid[m]),  32'(m_gid[m]));
        end
    endtask

    task automatic randomize_data();
        for (int c = 0; c < N; c++) begin
            ch_addr[c] = AW'($urandom);
            ch_data[c] = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; req_valid = '1;
        cyc = 0; rr_start = 0;
        for (int m = 0; m < 2; m++) begin
            m_wr[m] = 1'b0; m_addr[m] = '0; m_data[m] = '0; m_gid[m] = 0; wcnt[m] = 0;
        end
        randomize_data();

        // Reset with every master requesting.
        do_reset();

        // All masters valid, no backpressure: slice ownership rotates every SL beats.
        for (int t = 0; t < 5 * SL; t++) begin
            randomize_data();
            cycle();
        end

        // Only channel 2 valid: slice instance writes exactly one slice worth.
        do_reset();
        req_valid = 4'b0100;
        ch_addr[2] = 19'h00123;
        ch_data[2] = 16'hBEEF;
        wcnt[0] = 0; wcnt[1] = 0;
        for (int t = 0; t < 5 * SL; t++) cycle();
        chk("slice_idle_owner_writes", 32'(wcnt[0]), 32'(SL));
        chk("rr_single_master_writes", 32'(wcnt[1]), 32'(5 * SL - 1));

        // Round-robin over 1011, then channel 1 drops out.
        do_reset();
        req_valid = 4'b1011;
        for (int t = 0; t < 12; t++) begin
            randomize_data();
            cycle();
        end
        req_valid = 4'b1001;
        for (int t = 0; t < 12; t++) begin
            randomize_data();
            cycle();
        end

        // Backpressure: RAM stalls five cycles after the first accept.
        do_reset();
        req_valid = 4'b0001;
        mem_ready = 1'b1;
        randomize_data();
        cycle();
        mem_ready = 1'b0;
        for (int t = 0; t < 5; t++) cycle();
        mem_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            randomize_data();
            cycle();
        end

        // Reset while a beat is held under a stall: the beat must never appear.
        req_valid = 4'b0001;
        randomize_data();
        cycle();
        mem_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = '0;
        mem_ready = 1'b1;
        for (int t = 0; t < 3; t++) cycle();

        // Random traffic with random RAM backpressure.
        for (int t = 0; t < 300; t++) begin
            req_valid = N'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            randomize_data();
            cycle();
        end

        // Drain and confirm every accepted beat was written once.
        req_valid = '0;
        mem_ready = 1'b1;
        for (int t = 0; t < 3; t++) cycle();
        chk("sb_drained_m0", 32'(sbq0.size()), 32'd0);
        chk("sb_drained_m1", 32'(sbq1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
